muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Receives funct3 and both operands when the control path flags an M-extension R-type instruction (opcode 0110011, funct7 0000001).
- Holds busy so hazard logic stalls IF/ID/EX.
- Returns a 32-bit result with a one-cycle done pulse.

---
 rtl/riscv_m_pkg.sv | 22 ++
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 op selects, the M-extension funct7 and
// the multiply/divide unit state encoding.
package riscv_m_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on unsigned magnitudes, sign restored on the final iteration.
module muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  muldiv_state_t       state;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN:0]       prem;
  logic [XLEN-1:0]     mcand;
  logic [2:0]          op;
  logic                neg;

  function automatic logic [2*XLEN-1:0] sign_fix(input logic [2*XLEN-1:0] v,
                                                 input logic              n);
    return n ? -v : v;
  endfunction

  logic            sgn_a, sgn_b, is_div_in, div0, ovf, special, accept;
  logic [XLEN-1:0] abs_a, abs_b, spec_res;

  always_comb begin
    sgn_a     = srcA[XLEN-1] & ((funct3 == F3_MULH) | (funct3 == F3_MULHSU) |
                                (funct3 == F3_DIV)  | (funct3 == F3_REM));
    sgn_b     = srcB[XLEN-1] & ((funct3 == F3_MULH) | (funct3 == F3_DIV) |
                                (funct3 == F3_REM));
    abs_a     = sgn_a ? -srcA : srcA;
    abs_b     = sgn_b ? -srcB : srcB;
    is_div_in = funct3[2];
    div0      = is_div_in & (srcB == '0);
    ovf       = ((funct3 == F3_DIV) | (funct3 == F3_REM)) &
                (srcA == {1'b1, {(XLEN-1){1'b0}}}) & (srcB == '1);
    special   = div0 | ovf;
    // Remainder ops return the dividend on /0 and zero on overflow
    if (div0)
      spec_res = funct3[1] ? srcA : '1;
    else
      spec_res = funct3[1] ? '0 : srcA;
    accept    = start & ((state == IDLE) | (state == DONE));
  end

  logic [XLEN:0]     add_s, shin, trial, prem_nx;
  logic              qbit;
  logic [2*XLEN-1:0] mul_nx, div_nx, acc_nx, raw, fixed;
  logic [XLEN-1:0]   fin;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}
    add_s   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_nx  = {add_s, acc[XLEN-1:1]};
    // Divide: acc[XLEN-1:0] shifts dividend bits out and quotient bits in
    shin    = {prem[XLEN-1:0], acc[XLEN-1]};
    trial   = shin - {1'b0, mcand};
    qbit    = ~trial[XLEN];
    prem_nx = qbit ? trial : shin;
    div_nx  = {{XLEN{1'b0}}, acc[XLEN-2:0], qbit};
    acc_nx  = op[2] ? div_nx : mul_nx;
    if (op[2])
      raw = {{XLEN{1'b0}}, (op[1] ? prem_nx[XLEN-1:0] : div_nx[XLEN-1:0])};
    else
      raw = mul_nx;
    fixed   = sign_fix(raw, neg);
    fin     = (op[2] | (op == F3_MUL)) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      acc    <= '0;
      prem   <= '0;
      mcand  <= '0;
      op     <= F3_MUL;
      neg    <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept) begin
            op    <= funct3;
            cnt   <= '0;
            prem  <= '0;
            neg   <= (funct3[2] & funct3[1]) ? sgn_a : (sgn_a ^ sgn_b);
            mcand <= is_div_in ? abs_b : abs_a;
            acc   <= {{XLEN{1'b0}}, (is_div_in ? abs_a : abs_b)};
            if (special) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= spec_res;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc  <= acc_nx;
          prem <= prem_nx;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= fin;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with cycle-level compare,
// plus directed vectors with hand-computed results and latencies.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
    .funct3(funct3), .srcA(srcA), .srcB(srcB),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: {special, result} from plain 64-bit arithmetic
  function automatic logic [32:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, sp, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f)
      3'b000: begin p = ua * ub; return {1'b0, p[31:0]}; end
      3'b001: begin sp = sa * sb; p = sp; return {1'b0, p[63:32]}; end
      3'b010: begin sp = sa * ub; p = sp; return {1'b0, p[63:32]}; end
      3'b011: begin p = {32'h0, a} * {32'h0, b}; return {1'b0, p[63:32]}; end
      3'b100: begin
        if (b == 0) return {1'b1, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = sa / sb; p = q; return {1'b0, p[31:0]};
      end
      3'b101: begin
        if (b == 0) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, a / b};
      end
      3'b110: begin
        if (b == 0) return {1'b1, a};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h0};
        q = sa % sb; p = q; return {1'b0, p[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a};
        return {1'b0, a % b};
      end
    endcase
  endfunction

  wire [32:0] m_r = ref_op(funct3, srcA, srcB);

  logic        m_busy, m_done;
  logic [31:0] m_res, m_pend;
  int          m_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_pend <= '0;
      m_cnt  <= 0;
    end else if (flush) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (!m_busy && start) begin
      if (m_r[32]) begin
        m_done <= 1'b1;
        m_res  <= m_r[31:0];
      end else begin
        m_done <= 1'b0;
        m_busy <= 1'b1;
        m_cnt  <= 32;
        m_pend <= m_r[31:0];
      end
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pend;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("model busy", {31'h0, busy}, {31'h0, m_busy});
      chk("model done", {31'h0, done}, {31'h0, m_done});
      chk("model result", result, m_res);
    end
  end

  // Caller is at posedge+1; start is presented for one edge
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    bit saw_busy;
    funct3 = f; srcA = a; srcB = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 1;
    saw_busy = 1'b0;
    while (!done && n < 40) begin
      if (busy) saw_busy = 1'b1;
      @(posedge clk); #1 n++;
    end
    chk({name, " latency"}, 32'(n), 32'(lat));
    chk({name, " result"}, result, exp);
    if (lat == 1) chk({name, " busy seen"}, {31'h0, saw_busy}, 32'h0);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1 if (done) seen++;
    end
    chk({name, " stray done"}, 32'(seen), 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset done", {31'h0, done}, 32'h0);
    chk("reset result", result, 32'h0);

    run_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("MULHU max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("MULH min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 33);

    run_op("DIV by 0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REMU by 0", 3'b111, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
    run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    @(posedge clk); #1;

    // Flush in the tenth cycle of an operation
    funct3 = 3'b101; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush busy", {31'h0, busy}, 32'h0);
    chk("flush done", {31'h0, done}, 32'h0);
    chk("flush result", result, 32'h0);
    expect_quiet("flush", 40);

    // A second start while iterating must be ignored
    begin
      int n;
      funct3 = 3'b101; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      funct3 = 3'b000; srcA = 32'd3; srcB = 32'd3; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 6;
      while (!done && n < 40) begin @(posedge clk); #1 n++; end
      chk("ignored start latency", 32'(n), 32'd33);
      chk("ignored start result", result, 32'd14);
    end
    @(posedge clk); #1;

    // flush and start together: nothing starts
    funct3 = 3'b000; srcA = 32'd2; srcB = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    chk("flush+start busy", {31'h0, busy}, 32'h0);
    chk("flush+start done", {31'h0, done}, 32'h0);
    expect_quiet("flush+start", 40);

    // Asynchronous reset in the middle of an operation
    funct3 = 3'b000; srcA = 32'd7; srcB = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    chk("mid reset busy", {31'h0, busy}, 32'h0);
    chk("mid reset done", {31'h0, done}, 32'h0);
    chk("mid reset result", result, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    expect_quiet("after reset", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
